// File: rtl/bcd_digit_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_assembler_if
//  Description : Handshake bundle for the BCD digit assembler.
//                Digit side  : digit_in / digit_valid / digit_ready
//                Word side   : bcd_out / bcd_valid / bcd_ready
//                Control     : clear (synchronous abort)
//                Status      : digit_err / range_err / timeout_err pulses
//                modport slave  - the assembler itself
//                modport master - whatever drives digits and sinks words
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_digit_assembler_if;

    logic       clear;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic [7:0] bcd_out;
    logic       bcd_valid;
    logic       bcd_ready;
    logic       digit_err;
    logic       range_err;
    logic       timeout_err;

    modport slave (
        input  clear,
        input  digit_in,
        input  digit_valid,
        output digit_ready,
        output bcd_out,
        output bcd_valid,
        input  bcd_ready,
        output digit_err,
        output range_err,
        output timeout_err
    );

    modport master (
        output clear,
        output digit_in,
        output digit_valid,
        input  digit_ready,
        input  bcd_out,
        input  bcd_valid,
        output bcd_ready,
        input  digit_err,
        input  range_err,
        input  timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_assembler
//  Description : Collects a tens digit then a units digit over a valid/ready
//                handshake and presents the packed two-digit BCD word
//                {tens, units} through a registered valid/ready stage.
//                Bad digits, values above MAX_VALUE and a units digit that
//                arrives too late are reported as one-cycle error pulses.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - bcd_digit_assembler_if.slave (digit input,
//                         word output, clear, error pulses)
//  Parameters  : MAX_VALUE      - largest decimal value accepted
//                TIMEOUT_CYCLES - idle cycles allowed between tens and units
//                CNT_W          - timeout counter width, 2**CNT_W > TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_assembler #(
    parameter int unsigned MAX_VALUE      = 15,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  wire                    clk,
    input  wire                    rst_n,
    bcd_digit_assembler_if.slave   bus
);

    typedef enum logic [1:0] {
        WAIT_TENS  = 2'd0,
        WAIT_UNITS = 2'd1,
        HOLD       = 2'd2
    } state_t;

    localparam logic [6:0]       c_max_value    = 7'(MAX_VALUE);
    // The counter is checked before it increments, so expiry is detected on
    // the idle cycle that would bring it to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_tens;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_bcd_out;
    logic             r_bcd_valid;
    logic             r_digit_ready;
    logic             r_digit_err;
    logic             r_range_err;
    logic             r_timeout_err;

    logic             w_take;
    logic             w_digit_bad;
    logic [6:0]       w_value;

    assign w_take      = bus.digit_valid && r_digit_ready;
    assign w_digit_bad = (bus.digit_in > 4'd9);

    // tens*10 + units as tens*8 + tens*2 + units; max 9*10+9 = 99 fits 7 bits.
    assign w_value = {r_tens, 3'b000} + {2'b00, r_tens, 1'b0} + {3'b000, bus.digit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= WAIT_TENS;
            r_tens        <= 4'd0;
            r_cnt         <= '0;
            r_bcd_out     <= 8'h00;
            r_bcd_valid   <= 1'b0;
            r_digit_ready <= 1'b0;
            r_digit_err   <= 1'b0;
            r_range_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            // Error flags are pulses: cleared every cycle unless re-raised.
            r_digit_err   <= 1'b0;
            r_range_err   <= 1'b0;
            r_timeout_err <= 1'b0;

            if (bus.clear) begin
                // Abort outranks digits and the output handshake; bcd_out
                // keeps whatever it last held.
                r_state       <= WAIT_TENS;
                r_cnt         <= '0;
                r_bcd_valid   <= 1'b0;
                r_digit_ready <= 1'b1;
            end else begin
                case (r_state)
                    WAIT_TENS: begin
                        r_digit_ready <= 1'b1;
                        if (w_take) begin
                            if (w_digit_bad) begin
                                r_digit_err <= 1'b1;
                            end else begin
                                r_tens  <= bus.digit_in;
                                r_cnt   <= '0;
                                r_state <= WAIT_UNITS;
                            end
                        end
                    end

                    WAIT_UNITS: begin
                        if (w_take) begin
                            // An accepted digit beats a coincident expiry.
                            r_cnt <= '0;
                            if (w_digit_bad) begin
                                r_digit_err <= 1'b1;
                                r_state     <= WAIT_TENS;
                            end else if (w_value > c_max_value) begin
                                r_range_err <= 1'b1;
                                r_state     <= WAIT_TENS;
                            end else begin
                                r_bcd_out     <= {r_tens, bus.digit_in};
                                r_bcd_valid   <= 1'b1;
                                r_digit_ready <= 1'b0;
                                r_state       <= HOLD;
                            end
                        end else if (r_cnt == c_timeout_last) begin
                            r_timeout_err <= 1'b1;
                            r_cnt         <= '0;
                            r_state       <= WAIT_TENS;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    HOLD: begin
                        // No bypass: the next tens digit waits one cycle.
                        if (r_bcd_valid && bus.bcd_ready) begin
                            r_bcd_valid   <= 1'b0;
                            r_digit_ready <= 1'b1;
                            r_state       <= WAIT_TENS;
                        end
                    end

                    default: begin
                        r_state       <= WAIT_TENS;
                        r_cnt         <= '0;
                        r_bcd_valid   <= 1'b0;
                        r_digit_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.digit_ready = r_digit_ready;
    assign bus.bcd_out     = r_bcd_out;
    assign bus.bcd_valid   = r_bcd_valid;
    assign bus.digit_err   = r_digit_err;
    assign bus.range_err   = r_range_err;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_digit_assembler
//  Description : Directed bench for bcd_digit_assembler. Stimulus pushes the
//                expected word or error event into a queue; a monitor pops
//                and compares whenever the DUT completes a word handshake or
//                raises an error pulse. Cycle-exact properties (latency,
//                hold stability, reset/clear effects) are checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_assembler;

    localparam int K_WORD = 0;
    localparam int K_DERR = 1;
    localparam int K_RERR = 2;
    localparam int K_TERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    bcd_digit_assembler_if bus();

    bcd_digit_assembler #(
        .MAX_VALUE      (15),
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] data);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected nothing at %0t",
                     kind, data, $time);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.data !== data) begin
                n_bad++;
                $display("FAIL scoreboard: got kind %0d data %0h, expected kind %0d data %0h at %0t",
                         kind, data, e.kind, e.data, $time);
            end
        end
    endtask

    // Monitor: samples mid-cycle, when inputs and registered outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bcd_valid && bus.bcd_ready && !bus.clear) observe(K_WORD, bus.bcd_out);
            if (bus.digit_err)   observe(K_DERR, 8'h00);
            if (bus.range_err)   observe(K_RERR, 8'h00);
            if (bus.timeout_err) observe(K_TERR, 8'h00);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        bus.digit_in    = d;
        bus.digit_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        bus.digit_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        rst_n           = 1'b0;
        bus.clear       = 1'b0;
        bus.digit_in    = 4'd0;
        bus.digit_valid = 1'b0;
        bus.bcd_ready   = 1'b1;

        // Reset state
        tick();
        chk("rst_bcd_out",     {24'd0, bus.bcd_out},  32'h00);
        chk("rst_bcd_valid",   {31'd0, bus.bcd_valid}, 32'd0);
        chk("rst_digit_ready", {31'd0, bus.digit_ready}, 32'd0);
        chk("rst_errs", {29'd0, bus.digit_err, bus.range_err, bus.timeout_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, bus.digit_ready}, 32'd1);

        // 1: back-to-back 1,3 -> 8'h13 valid for exactly one cycle
        push(K_WORD, 8'h13);
        send(4'd1);
        send(4'd3);
        chk("t1_valid", {31'd0, bus.bcd_valid}, 32'd1);
        chk("t1_out",   {24'd0, bus.bcd_out},   32'h13);
        idle(1);
        chk("t1_valid_drop", {31'd0, bus.bcd_valid}, 32'd0);

        // 2: 0,7 held under backpressure; digit offered in HOLD is ignored
        bus.bcd_ready = 1'b0;
        push(K_WORD, 8'h07);
        send(4'd0);
        send(4'd7);
        bus.digit_in = 4'd5;
        for (int i = 0; i < 5; i++) begin
            chk("t2_ready_hold", {31'd0, bus.digit_ready}, 32'd0);
            chk("t2_out_hold",   {24'd0, bus.bcd_out},    32'h07);
            chk("t2_valid_hold", {31'd0, bus.bcd_valid},  32'd1);
            tick();
        end
        bus.digit_valid = 1'b0;
        bus.bcd_ready   = 1'b1;
        tick();
        chk("t2_valid_drop", {31'd0, bus.bcd_valid},   32'd0);
        chk("t2_ready_back", {31'd0, bus.digit_ready}, 32'd1);

        // 3: bad tens digit, then 1,5; bad units digit drops tens, then 0,9
        push(K_DERR, 8'h00);
        send(4'hA);
        chk("t3_ready_after_derr", {31'd0, bus.digit_ready}, 32'd1);
        push(K_WORD, 8'h15);
        send(4'd1);
        send(4'd5);
        idle(1);
        push(K_DERR, 8'h00);
        send(4'd1);
        send(4'hC);
        push(K_WORD, 8'h09);
        send(4'd0);
        send(4'd9);
        chk("t3_out_09", {24'd0, bus.bcd_out}, 32'h09);
        idle(1);

        // 4: 16 exceeds MAX_VALUE
        push(K_RERR, 8'h00);
        send(4'd1);
        send(4'd6);
        chk("t4_no_valid", {31'd0, bus.bcd_valid}, 32'd0);
        idle(1);

        // 5: timeout after 4 idle cycles, then 2,3 -> range error,
        //    then units on the expiry cycle wins
        push(K_TERR, 8'h00);
        send(4'd1);
        idle(3);
        chk("t5_no_early_timeout", {31'd0, bus.timeout_err}, 32'd0);
        idle(1);
        chk("t5_timeout", {31'd0, bus.timeout_err}, 32'd1);
        push(K_RERR, 8'h00);
        send(4'd2);
        send(4'd3);
        push(K_WORD, 8'h14);
        send(4'd1);
        idle(3);
        send(4'd4);
        chk("t5_expiry_no_terr", {31'd0, bus.timeout_err}, 32'd0);
        chk("t5_expiry_valid",   {31'd0, bus.bcd_valid},   32'd1);
        idle(1);

        // 6: clear in WAIT_UNITS beats a coincident digit
        send(4'd1);
        bus.clear    = 1'b1;
        bus.digit_in = 4'd2;
        tick();
        bus.clear = 1'b0;
        chk("t6_clr_units_valid", {31'd0, bus.bcd_valid},   32'd0);
        chk("t6_clr_units_ready", {31'd0, bus.digit_ready}, 32'd1);
        push(K_WORD, 8'h05);
        send(4'd0);
        send(4'd5);
        idle(1);

        // clear in HOLD together with bcd_ready: no word, bcd_out retained
        bus.bcd_ready = 1'b0;
        send(4'd0);
        send(4'd8);
        bus.digit_valid = 1'b0;
        chk("t6_hold_valid", {31'd0, bus.bcd_valid}, 32'd1);
        bus.clear     = 1'b1;
        bus.bcd_ready = 1'b1;
        tick();
        bus.clear     = 1'b0;
        bus.bcd_ready = 1'b0;
        chk("t6_clr_hold_valid", {31'd0, bus.bcd_valid},   32'd0);
        chk("t6_clr_hold_out",   {24'd0, bus.bcd_out},     32'h08);
        chk("t6_clr_hold_ready", {31'd0, bus.digit_ready}, 32'd1);

        // asynchronous reset in the middle of HOLD
        send(4'd0);
        send(4'd9);
        idle(1);
        chk("t6_pre_rst_valid", {31'd0, bus.bcd_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, bus.bcd_valid},   32'd0);
        chk("t6_async_out",   {24'd0, bus.bcd_out},     32'h00);
        chk("t6_async_ready", {31'd0, bus.digit_ready}, 32'd0);
        idle(2);

        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
